// File: rtl/ahbram_responder_pkg.sv
// ---------------------------------------------------------------------------
// ahbram_responder_pkg
// Shared definitions for the AHB-Lite RAM responder:
//   - AHB HTRANS / HRESP encodings
//   - ahbramstate_t : data-phase state machine encoding
//   - cnt_width()   : width of the wait-state counter for a given latency
// ---------------------------------------------------------------------------
package ahbram_responder_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } ahbramstate_t;

    // Counter must hold RAM_LATENCY-1; never narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ahbram_responder_ram1p1rwbe.sv
// ---------------------------------------------------------------------------
// ram1p1rwbe
// Single-port RAM with per-byte write enables and a registered read port.
// A write and a read share the one address; on a write cycle the output
// register captures the contents *before* the write (read-old-data).
// Ports:
//   clk  : clock
//   ce   : port enable (read and/or write this cycle)
//   we   : write enable (qualified by ce)
//   bwe  : byte write enables
//   addr : word address
//   din  : write data
//   dout : registered read data (holds when ce is low)
// ---------------------------------------------------------------------------
module ram1p1rwbe #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic                     we,
    input  logic [WIDTH/8-1:0]       bwe,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage carries no reset so it maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
        if (ce) begin
            dout <= mem[addr];
            if (we) begin
                for (int b = 0; b < WIDTH/8; b++) begin
                    if (bwe[b]) begin
                        mem[addr][b*8 +: 8] <= din[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ahbram_responder.sv
// ---------------------------------------------------------------------------
// ahbram_responder
// AHB-Lite subordinate RAM with a configurable number of wait states and
// optional zero-wait continuation of SEQ burst beats.
//
// Optional feature macro: AHBRAM_ERRRESP_EN
//   defined   : accesses outside BASE/RANGE get a two-cycle ERROR response
//               (ERR1, ERR2) and never touch the array.
//   undefined : upper address bits are ignored (accesses alias modulo the
//               array size) and HRESP is always OKAY.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   HSEL, HADDR,      : address phase (accepted when HSEL & HREADY & HTRANS[1])
//   HWRITE, HTRANS,
//   HBURST, HSIZE
//   HWSTRB, HWDATA    : data-phase write strobes and data
//   HREADY            : bus-level ready
//   HRDATA            : read data (holds last read value between reads)
//   HREADYOUT, HRESP  : data-phase completion and response
// ---------------------------------------------------------------------------
module ahbram_responder
    import ahbram_responder_pkg::*;
#(
    parameter int                  AHBW        = 64,
    parameter int                  PA_BITS     = 32,
    parameter int                  RAM_LATENCY = 3,
    parameter bit                  BURST_EN    = 1'b1,
    parameter logic [PA_BITS-1:0]  BASE        = 'h8000_0000,
    parameter logic [PA_BITS-1:0]  RANGE       = 'h0000_0FFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 HSEL,
    input  logic [PA_BITS-1:0]   HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HBURST,
    input  logic [2:0]           HSIZE,
    input  logic [AHBW/8-1:0]    HWSTRB,
    input  logic [AHBW-1:0]      HWDATA,
    input  logic                 HREADY,
    output logic [AHBW-1:0]      HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP
);

    localparam int NB    = AHBW / 8;
    localparam int OFS   = $clog2(NB);
    localparam int ABITS = $clog2({1'b0, RANGE} + 1'b1);
    localparam int IDX_W = ABITS - OFS;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = cnt_width(RAM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (RAM_LATENCY > 0) ? CNT_W'(RAM_LATENCY - 1) : '0;

    ahbramstate_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              fwd_q;
    logic [AHBW-1:0]   fwd_data_q;
    logic [NB-1:0]     fwd_strb_q;
    logic [AHBW-1:0]   hrdata_q;

    logic              accept;
    logic              take;
    logic              in_range;
    logic              lat_zero;
    logic              conflict;
    logic              wr_now;
    logic              rd_issue;
    logic              rd_phase;
    logic [IDX_W-1:0]  new_idx;
    logic              ram_ce;
    logic [IDX_W-1:0]  ram_addr;
    logic [AHBW-1:0]   ram_dout;
    logic [AHBW-1:0]   merged;
    logic              unused_ok;

    // HBURST/HSIZE are informational; only the indexed HADDR bits matter.
    assign unused_ok = ^{HBURST, HSIZE, HADDR, BASE};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign accept  = HSEL & HREADY & HTRANS[1];
    // ERR1 holds HREADY low and an accept in ERR2 is cancelled by the
    // initiator, so only IDLE and DATA take new transfers.
    assign take    = accept & ((state_q == IDLE) | (state_q == DATA));
    assign new_idx = HADDR[ABITS-1:OFS];
    assign lat_zero = (RAM_LATENCY == 0) || (BURST_EN && (HTRANS == HTRANS_SEQ));

`ifdef AHBRAM_ERRRESP_EN
    assign in_range = ((HADDR & ~RANGE) == (BASE & ~RANGE));
`else
    assign in_range = 1'b1;
`endif

    // The single RAM port is busy writing during a write data phase. A
    // zero-latency read to the same word can share that cycle (the RAM
    // returns old data and the write bytes are forwarded on top); a read to
    // a different word cannot, so it takes a one-cycle turnaround wait.
    assign conflict = (state_q == DATA) & write_q & ~HWRITE & lat_zero &
                      (new_idx != idx_q);

    assign wr_now   = (state_q == DATA) & write_q;
    assign rd_phase = (state_q == DATA) & ~write_q;
    assign rd_issue = ((state_q == WAIT) & (cnt_q == '0) & ~write_q) |
                      (take & in_range & ~HWRITE & lat_zero & ~conflict);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_strb_q <= '0;
            hrdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                idx_q   <= new_idx;
                write_q <= HWRITE;
            end
            // Only a read issued alongside a write needs the write bytes
            // merged into the RAM's old-data output next cycle.
            fwd_q      <= wr_now & rd_issue;
            fwd_data_q <= HWDATA;
            fwd_strb_q <= HWSTRB;
            hrdata_q   <= HRDATA;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DATA: begin
                if (take) begin
                    if (!in_range) begin
                        state_d = ERR1;
                    end else if (!lat_zero) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else if (conflict) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef AHBRAM_ERRRESP_EN
            ERR1: state_d = ERR2;
            ERR2: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            WAIT: HREADYOUT = 1'b0;
`ifdef AHBRAM_ERRRESP_EN
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ERR2: HRESP = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage and read path
    // ------------------------------------------------------------------
    assign ram_ce   = (wr_now | rd_issue) & ~reset;
    assign ram_addr = wr_now ? idx_q : ((state_q == WAIT) ? idx_q : new_idx);

    ram1p1rwbe #(
        .DEPTH (DEPTH),
        .WIDTH (AHBW)
    ) u_ram (
        .clk  (clk),
        .ce   (ram_ce),
        .we   (wr_now),
        .bwe  (HWSTRB),
        .addr (ram_addr),
        .din  (HWDATA),
        .dout (ram_dout)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_fwd
            assign merged[gi*8 +: 8] = (fwd_q && fwd_strb_q[gi]) ?
                                       fwd_data_q[gi*8 +: 8] : ram_dout[gi*8 +: 8];
        end
    endgenerate

    assign HRDATA = rd_phase ? merged : hrdata_q;

endmodule

// File: tb/tb_ahbram_responder.sv
`timescale 1ns/1ps
module tb_ahbram_responder;
    import ahbram_responder_pkg::*;

    localparam int PA = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        hsel;
    logic [PA-1:0]     haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic [7:0]        hwstrb;
    logic [63:0]       hwdata;
    logic [63:0]       hrdata_o [3];
    logic [2:0]        hready_o;
    logic [2:0]        hresp_o;

    int n_vec = 0;
    int n_err = 0;

    // transfer table for the pipelined bus driver
    logic [PA-1:0] t_addr  [8];
    logic          t_wr    [8];
    logic [1:0]    t_trans [8];
    logic [63:0]   t_wdata [8];
    logic [7:0]    t_strb  [8];
    logic [63:0]   r_data  [8];
    int            r_waits [8];
    logic          r_resp  [8];

    always #5 clk = ~clk;

    // 0: latency 3, bursts zero-wait   1: latency 3, no burst   2: latency 0
    ahbram_responder #(.AHBW(64), .PA_BITS(PA), .RAM_LATENCY(3), .BURST_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HBURST(hburst), .HSIZE(hsize), .HWSTRB(hwstrb), .HWDATA(hwdata),
        .HREADY(hready_o[0]), .HRDATA(hrdata_o[0]), .HREADYOUT(hready_o[0]), .HRESP(hresp_o[0]));

    ahbram_responder #(.AHBW(64), .PA_BITS(PA), .RAM_LATENCY(3), .BURST_EN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HBURST(hburst), .HSIZE(hsize), .HWSTRB(hwstrb), .HWDATA(hwdata),
        .HREADY(hready_o[1]), .HRDATA(hrdata_o[1]), .HREADYOUT(hready_o[1]), .HRESP(hresp_o[1]));

    ahbram_responder #(.AHBW(64), .PA_BITS(PA), .RAM_LATENCY(0), .BURST_EN(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .HSEL(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HBURST(hburst), .HSIZE(hsize), .HWSTRB(hwstrb), .HWDATA(hwdata),
        .HREADY(hready_o[2]), .HRDATA(hrdata_o[2]), .HREADYOUT(hready_o[2]), .HRESP(hresp_o[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    task automatic set_t(input int i, input logic [PA-1:0] a, input logic w,
                         input logic [1:0] tr, input logic [63:0] d, input logic [7:0] s);
        t_addr[i] = a; t_wr[i] = w; t_trans[i] = tr; t_wdata[i] = d; t_strb[i] = s;
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Pipelined AHB initiator: call at posedge+1, returns at posedge+1.
    task automatic run_seq(input int sel, input int n);
        int a; int d; int cyc; logic hr;
        a = 0; d = -1; cyc = 0;
        for (int i = 0; i < n; i++) begin
            r_waits[i] = 0; r_data[i] = '0; r_resp[i] = 1'b0;
        end
        while (a < n || d >= 0) begin
            hsel = '0;
            if (a < n) begin
                hsel[sel] = 1'b1; haddr = t_addr[a]; hwrite = t_wr[a]; htrans = t_trans[a];
            end else begin
                htrans = HTRANS_IDLE; hwrite = 1'b0;
            end
            if (d >= 0) begin
                hwdata = t_wdata[d]; hwstrb = t_strb[d];
            end
            @(negedge clk);
            hr = hready_o[sel];
            if (d >= 0) begin
                if (hr) begin
                    r_data[d] = hrdata_o[sel]; r_resp[d] = hresp_o[sel];
                end else begin
                    r_waits[d]++;
                end
            end
            @(posedge clk); #1;
            if (hr) begin
                if (a < n) begin d = a; a++; end
                else d = -1;
            end
            cyc++;
            if (cyc > 200) begin
                n_vec++; n_err++;
                $error("FAIL timeout: observed %0d cycles required <= 200", cyc);
                hsel = '0; htrans = HTRANS_IDLE;
                return;
            end
        end
        hsel = '0; htrans = HTRANS_IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bd [4];
        reset = 1'b1; hsel = '0; haddr = '0; hwrite = 1'b0; htrans = HTRANS_IDLE;
        hburst = 3'b000; hsize = 3'd3; hwstrb = '0; hwdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_hreadyout0", {63'd0, hready_o[0]}, 64'd1);
        chk("rst_hresp0",     {63'd0, hresp_o[0]},  64'd0);
        chk("rst_hrdata0",    hrdata_o[0],          64'd0);
        chk("rst_hreadyout2", {63'd0, hready_o[2]}, 64'd1);
        sync();

        // single NONSEQ write then read, latency 3
        set_t(0, 32'h8000_0010, 1'b1, HTRANS_NONSEQ, 64'h0123_4567_89AB_CDEF, 8'hFF);
        run_seq(0, 1);
        chk("single_wr_waits", 64'(r_waits[0]), 64'd3);
        set_t(0, 32'h8000_0010, 1'b0, HTRANS_NONSEQ, 64'd0, 8'h00);
        run_seq(0, 1);
        chk("single_rd_waits", 64'(r_waits[0]), 64'd3);
        chk("single_rd_data",  r_data[0], 64'h0123_4567_89AB_CDEF);

        // INCR4 burst, zero-wait continuation
        hburst = 3'b011;
        bd[0] = 64'h11; bd[1] = 64'h22; bd[2] = 64'h33; bd[3] = 64'h44;
        for (int i = 0; i < 4; i++)
            set_t(i, 32'h8000_0100 + 32'(i*8), 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, bd[i], 8'hFF);
        run_seq(0, 4);
        chk("b1_wr_waits0", 64'(r_waits[0]), 64'd3);
        chk("b1_wr_waits3", 64'(r_waits[3]), 64'd0);
        for (int i = 0; i < 4; i++)
            set_t(i, 32'h8000_0100 + 32'(i*8), 1'b0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 64'd0, 8'h00);
        run_seq(0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b1_rd_waits%0d", i), 64'(r_waits[i]), (i == 0) ? 64'd3 : 64'd0);
            chk($sformatf("b1_rd_data%0d", i),  r_data[i], bd[i]);
        end

        // same burst with burst continuation disabled: every beat waits
        for (int i = 0; i < 4; i++)
            set_t(i, 32'h8000_0200 + 32'(i*8), 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, bd[i], 8'hFF);
        run_seq(1, 4);
        chk("b0_wr_waits1", 64'(r_waits[1]), 64'd3);
        for (int i = 0; i < 4; i++)
            set_t(i, 32'h8000_0200 + 32'(i*8), 1'b0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 64'd0, 8'h00);
        run_seq(1, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b0_rd_waits%0d", i), 64'(r_waits[i]), 64'd3);
            chk($sformatf("b0_rd_data%0d", i),  r_data[i], bd[i]);
        end
        hburst = 3'b000;

        // latency 0: write, partial write, immediate read of same word
        set_t(0, 32'h8000_0040, 1'b1, HTRANS_NONSEQ, 64'h1111_2222_3333_4444, 8'hFF);
        set_t(1, 32'h8000_0040, 1'b1, HTRANS_NONSEQ, 64'hDEAD_BEEF_AABB_CCDD, 8'h0F);
        set_t(2, 32'h8000_0040, 1'b0, HTRANS_NONSEQ, 64'd0, 8'h00);
        run_seq(2, 3);
        chk("fwd_waits0",  64'(r_waits[0]), 64'd0);
        chk("fwd_waits2",  64'(r_waits[2]), 64'd0);
        chk("fwd_rd_data", r_data[2], 64'h1111_2222_AABB_CCDD);

        // HRDATA holds the last read value across a later write
        set_t(0, 32'h8000_0048, 1'b1, HTRANS_NONSEQ, 64'h5555_6666_7777_8888, 8'hFF);
        run_seq(2, 1);
        @(negedge clk);
        chk("hrdata_hold", hrdata_o[2], 64'h1111_2222_AABB_CCDD);
        sync();
        set_t(0, 32'h8000_0040, 1'b0, HTRANS_NONSEQ, 64'd0, 8'h00);
        run_seq(2, 1);
        chk("fwd_reread", r_data[0], 64'h1111_2222_AABB_CCDD);

        // reset asserted while waiting
        hsel = 3'b001; haddr = 32'h8000_0010; hwrite = 1'b0; htrans = HTRANS_NONSEQ;
        sync();
        hsel = '0; htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("mid_wait_low", {63'd0, hready_o[0]}, 64'd0);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_hreadyout", {63'd0, hready_o[0]}, 64'd1);
        chk("post_rst_hresp",     {63'd0, hresp_o[0]},  64'd0);
        chk("post_rst_hrdata",    hrdata_o[0],          64'd0);
        sync();
        set_t(0, 32'h8000_0010, 1'b0, HTRANS_NONSEQ, 64'd0, 8'h00);
        run_seq(0, 1);
        chk("post_rst_rd_waits", 64'(r_waits[0]), 64'd3);
        chk("post_rst_rd_data",  r_data[0], 64'h0123_4567_89AB_CDEF);

`ifdef AHBRAM_ERRRESP_EN
        // out-of-range write: two-cycle ERROR, array untouched
        set_t(0, 32'h8000_1040, 1'b1, HTRANS_NONSEQ, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        run_seq(2, 1);
        chk("err_waits", 64'(r_waits[0]), 64'd1);
        chk("err_resp",  {63'd0, r_resp[0]}, 64'd1);
        set_t(0, 32'h8000_0040, 1'b0, HTRANS_NONSEQ, 64'd0, 8'h00);
        run_seq(2, 1);
        chk("err_array_kept", r_data[0], 64'h1111_2222_AABB_CCDD);
        chk("err_after_resp", {63'd0, r_resp[0]}, 64'd0);
`else
        // out-of-range address aliases modulo the array size
        set_t(0, 32'h8000_1050, 1'b1, HTRANS_NONSEQ, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF);
        run_seq(2, 1);
        chk("alias_wr_resp", {63'd0, r_resp[0]}, 64'd0);
        set_t(0, 32'h8000_0050, 1'b0, HTRANS_NONSEQ, 64'd0, 8'h00);
        run_seq(2, 1);
        chk("alias_rd_data", r_data[0], 64'hCAFE_F00D_0BAD_BEEF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahbram_responder.md
# ahbram_responder

AHB-Lite subordinate RAM for the uncore that answers the core's AHB initiator (EBU) with a configurable number of wait states and optional zero-wait burst continuation. It is used as the uncore RAM and latency-stress target at P.UNCORE_RAM_BASE, and exercises HREADY back-pressure paths in the bus interface. Storage is a single-port byte-enabled array; the block implements the AHB data-phase state machine, latency counter and write/read hazard forwarding around it.

## Interface
- P: cvw_t, no default; uses P.AHBW, P.PA_BITS, P.RAM_LATENCY, P.BURST_EN, P.UNCORE_RAM_RANGE
- RANGE: P.UNCORE_RAM_RANGE; byte address mask; array depth = (RANGE+1)/(P.AHBW/8) words

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- HSEL  in  1  subordinate select
- HADDR  in  P.PA_BITS  address-phase address
- HWRITE  in  1  1 = write
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HBURST  in  3  burst type (informational except SEQ handling)
- HSIZE  in  3  transfer size
- HWSTRB  in  P.AHBW/8  data-phase byte strobes
- HWDATA  in  P.AHBW  data-phase write data
- HREADY  in  1  bus-level ready (address phase accepted when high)
- HRDATA  out  P.AHBW  read data
- HREADYOUT  out  1  data-phase complete
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Accept: HSEL & HREADY & HTRANS[1] captures HADDR, HWRITE into address register; word index = HADDR[log2(RANGE):log2(P.AHBW/8)].
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: on accept -> WAIT if latency L>0 else DATA; latency L = P.RAM_LATENCY for NONSEQ; for SEQ L = 0 when P.BURST_EN, else P.RAM_LATENCY.
- WAIT: counter loads L-1 on accept, decrements each cycle; at 0 -> DATA.
- DATA: HREADYOUT=1 for one cycle; write commits HWDATA under HWSTRB at end of this cycle; read drives HRDATA from array. Simultaneous new accept -> WAIT/DATA per new L, else IDLE.
- IDLE/BUSY transfers or HSEL=0: zero-wait OKAY, no array access; BUSY inside a burst does not disturb pending counter.
- Read to address written in the immediately preceding data phase returns the new bytes (forward merged strobes).
- Reset mid-transfer: FSM -> IDLE, counter 0, pending transfer dropped, array contents preserved.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM IDLE, counter 0.
- Accept at cycle t: HREADYOUT low cycles t+1..t+L, high at t+L+1 with HRDATA valid (read) / HWDATA sampled (write).
- L=0: full pipelining, one beat per cycle.
- Counter width ceil(log2(P.RAM_LATENCY+1)), minimum 1; P.RAM_LATENCY=0 removes WAIT.
- HRDATA holds last read value outside read data phases.

## Configuration
- AHBRAM_ERRRESP_EN defined: accept with (HADDR & ~RANGE) != (captured base bits) i.e. out-of-range -> two-cycle ERROR: ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1), then IDLE; no array write. Accept in ERR1 is impossible (HREADY low); accept in ERR2 is ignored per AHB (initiator cancels).
- Undefined: no ERR states; address bits above RANGE ignored, accesses alias modulo array size; HRESP tied 0.

## Structure
- Shared package: AHB HTRANS/HRESP constants, enum ahbramstate_t {IDLE, WAIT, DATA, ERR1, ERR2}.
- One sub-module: ram1p1rwbe (existing byte-enable single-port RAM) for storage; FSM, counter, forwarding in the top.

## Test plan
- P.RAM_LATENCY=3, NONSEQ read 0x80000010 -> HREADYOUT low 3 cycles, high on 4th with preloaded word.
- P.BURST_EN=1, INCR4 write 0x11,0x22,0x33,0x44 then INCR4 read -> first beat 3 waits, next 3 beats zero-wait, data matches.
- P.BURST_EN=0 same burst -> every beat 3 waits.
- Write strobe 0x0F value 0xAABBCCDD then immediate read same address, L=0 -> merged bytes returned.
- Assert reset in WAIT -> next cycle HREADYOUT=1, HRESP=0, earlier written data still readable.
- AHBRAM_ERRRESP_EN, access beyond RANGE -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, array unchanged.
